atomic_counter_reader: RTL and testbench

//  Initiator side of the atomic 64-bit counter read interface.
//  - On one read command, issues two back-to-back requests to the counter responder:
//    - an atomic request (atomic_o=1), which returns count[31:0] and makes the responder snapshot count[63:32];
//    - a non-atomic request (atomic_o=0), which returns that snapshot.
//  - Assembles the two words into one coherent 64-bit value and presents it on a valid/ready port.
//  - Aborts with an error flag if the responder fails to ack in time.

---
 rtl/atomic_counter_reader.sv | 169 ++++++++++++++++
 tb/tb_atomic_counter_reader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atomic_counter_reader.sv
// atomic_counter_reader
// Initiator side of the atomic 64-bit counter read interface. One read
// command becomes two responder requests: an atomic one that returns the
// low word and freezes the high word in the responder, then a plain one
// that returns the frozen high word. The two words are presented together
// on a valid/ready result port, or as an error if an ack never arrives.

module atomic_counter_reader #(
    parameter int DATA_W      = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rd_req_i,
    output logic                  rd_busy_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [2*DATA_W-1:0]   rd_data_o,
    output logic                  rd_err_o,
    output logic                  req_o,
    output logic                  atomic_o,
    input  logic                  ack_i,
    input  logic [DATA_W-1:0]     count_i
);

    // Timer holds 0..ACK_TIMEOUT-1; width sized for ACK_TIMEOUT+1 values.
    localparam int TMR_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ_LO  = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_REQ_HI  = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t                 state_r;
    logic [TMR_W-1:0]       timer_r;
    logic [DATA_W-1:0]      lo_r;
    logic [2*DATA_W-1:0]    data_r;
    logic                   err_r;
    logic                   valid_r;
    logic                   busy_r;
    logic                   req_r;
    logic                   atomic_r;
    logic                   timer_last_s;

    // Flag the last permitted wait cycle of the current phase.
    always_comb begin
        timer_last_s = 1'b0;
        if (timer_r == TMR_LAST) begin
            timer_last_s = 1'b1;
        end else begin
            timer_last_s = 1'b0;
        end
    end

    // Read sequencer: every output is a register updated together with the
    // state it belongs to, so nothing combinational reaches a port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            timer_r  <= '0;
            lo_r     <= '0;
            data_r   <= '0;
            err_r    <= 1'b0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            req_r    <= 1'b0;
            atomic_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Requests are only looked at here; anything raised
                    // while busy or in DONE is simply never seen.
                    if (rd_req_i) begin
                        state_r  <= ST_REQ_LO;
                        busy_r   <= 1'b1;
                        req_r    <= 1'b1;
                        atomic_r <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end

                ST_REQ_LO: begin
                    req_r    <= 1'b0;
                    atomic_r <= 1'b0;
                    timer_r  <= '0;
                    state_r  <= ST_WAIT_LO;
                end

                ST_WAIT_LO: begin
                    // Ack is tested before the limit so a last-cycle ack wins.
                    if (ack_i) begin
                        lo_r     <= count_i;
                        req_r    <= 1'b1;
                        atomic_r <= 1'b0;
                        state_r  <= ST_REQ_HI;
                    end else if (timer_last_s) begin
                        // No low word: skip the high phase entirely.
                        data_r   <= '0;
                        err_r    <= 1'b1;
                        valid_r  <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        timer_r  <= timer_r + TMR_W'(1);
                    end
                end

                ST_REQ_HI: begin
                    req_r    <= 1'b0;
                    atomic_r <= 1'b0;
                    timer_r  <= '0;
                    state_r  <= ST_WAIT_HI;
                end

                ST_WAIT_HI: begin
                    if (ack_i) begin
                        data_r   <= {count_i, lo_r};
                        err_r    <= 1'b0;
                        valid_r  <= 1'b1;
                        state_r  <= ST_DONE;
                    end else if (timer_last_s) begin
                        data_r   <= '0;
                        err_r    <= 1'b1;
                        valid_r  <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        timer_r  <= timer_r + TMR_W'(1);
                    end
                end

                ST_DONE: begin
                    // Result held until accepted; IDLE is always visited
                    // for one cycle before a new request can be taken.
                    if (rd_ready_i) begin
                        valid_r  <= 1'b0;
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        state_r  <= ST_DONE;
                    end
                end

                default: begin
                    state_r  <= ST_IDLE;
                    timer_r  <= '0;
                    valid_r  <= 1'b0;
                    busy_r   <= 1'b0;
                    req_r    <= 1'b0;
                    atomic_r <= 1'b0;
                    err_r    <= 1'b0;
                    data_r   <= '0;
                end
            endcase
        end
    end

    assign rd_busy_o  = busy_r;
    assign rd_valid_o = valid_r;
    assign rd_data_o  = data_r;
    assign rd_err_o   = err_r;
    assign req_o      = req_r;
    assign atomic_o   = atomic_r;

endmodule

// File: tb/tb_atomic_counter_reader.sv
// Directed bench for atomic_counter_reader with a small responder model
// whose ack delay and per-phase ack enable are set by the stimulus.

module tb_atomic_counter_reader;

    logic        clk;
    logic        reset_n;
    logic        rd_req_i;
    logic        rd_busy_o;
    logic        rd_valid_o;
    logic        rd_ready_i;
    logic [63:0] rd_data_o;
    logic        rd_err_o;
    logic        req_o;
    logic        atomic_o;
    logic        ack_i;
    logic [31:0] count_i;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Responder model controls
    logic [31:0] resp_lo;
    logic [31:0] resp_hi;
    logic [31:0] snap_hi;
    int          ack_dly;
    logic        lo_en;
    logic        hi_en;
    logic        spur_en;
    int          resp_cnt;
    logic        pend_atomic;

    atomic_counter_reader #(.DATA_W(32), .ACK_TIMEOUT(15)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_req_i   (rd_req_i),
        .rd_busy_o  (rd_busy_o),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .rd_data_o  (rd_data_o),
        .rd_err_o   (rd_err_o),
        .req_o      (req_o),
        .atomic_o   (atomic_o),
        .ack_i      (ack_i),
        .count_i    (count_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Responder: acks ack_dly cycles after seeing req_o; atomic request
    // returns the low word and snapshots the high word.
    initial begin
        ack_i       = 1'b0;
        count_i     = 32'h0;
        resp_cnt    = 0;
        pend_atomic = 1'b0;
        snap_hi     = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            ack_i   = 1'b0;
            count_i = 32'h0;
            if (resp_cnt > 0) begin
                resp_cnt = resp_cnt - 1;
                if (resp_cnt == 0) begin
                    if (pend_atomic) begin
                        if (lo_en) begin
                            ack_i   = 1'b1;
                            count_i = resp_lo;
                            snap_hi = resp_hi;
                        end
                    end else if (hi_en) begin
                        ack_i   = 1'b1;
                        count_i = snap_hi;
                    end
                end
            end
            if (req_o === 1'b1) begin
                resp_cnt    = ack_dly;
                pend_atomic = atomic_o;
            end
            if (spur_en) begin
                ack_i   = 1'b1;
                count_i = 32'hDEAD_BEEF;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Pulse rd_req_i across one edge; returns in cycle 1 of the read.
    task automatic start_read();
        rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
    endtask

    // From cycle 1, advance until rd_valid_o; report cycle index and requests seen.
    task automatic wait_valid(input int limit, output int n, output int reqs, output int hi_reqs);
        n = 1;
        reqs = 0;
        hi_reqs = 0;
        while (rd_valid_o !== 1'b1 && n < limit) begin
            if (req_o === 1'b1) reqs++;
            if (req_o === 1'b1 && atomic_o === 1'b0) hi_reqs++;
            tick();
            n++;
        end
        if (rd_valid_o !== 1'b1) check_eq("wait_valid_timeout", 64'(rd_valid_o), 64'd1);
    endtask

    task automatic finish_read();
        rd_ready_i = 1'b1;
        tick();
        rd_ready_i = 1'b0;
        check_eq("ready_drops_valid", 64'(rd_valid_o), 64'd0);
        check_eq("ready_to_idle", 64'(rd_busy_o), 64'd0);
    endtask

    initial begin
        int n, reqs, hi_reqs, accepts, valids;
        reset_n    = 1'b0;
        rd_req_i   = 1'b0;
        rd_ready_i = 1'b0;
        resp_lo    = 32'hFFFF_FFF0;
        resp_hi    = 32'h0000_0005;
        ack_dly    = 1;
        lo_en      = 1'b1;
        hi_en      = 1'b1;
        spur_en    = 1'b0;
        tick();
        tick();
        check_eq("rst_ctrl", 64'({rd_busy_o, rd_valid_o, req_o, atomic_o, rd_err_o}), 64'd0);
        check_eq("rst_data", rd_data_o, 64'd0);
        reset_n = 1'b1;
        tick();

        // 1: basic read, cycle-exact
        start_read();
        check_eq("t1_c1_req", 64'({req_o, atomic_o, rd_busy_o}), 64'b111);
        tick();
        check_eq("t1_c2_req", 64'(req_o), 64'd0);
        tick();
        check_eq("t1_c3_req", 64'({req_o, atomic_o}), 64'b10);
        tick();
        check_eq("t1_c4_valid", 64'(rd_valid_o), 64'd0);
        tick();
        check_eq("t1_c5_valid", 64'({rd_valid_o, rd_err_o, rd_busy_o}), 64'b101);
        check_eq("t1_c5_data", rd_data_o, 64'h0000_0005_FFFF_FFF0);

        // 2: held result while not ready
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t2_hold_valid", 64'(rd_valid_o), 64'd1);
            check_eq("t2_hold_data", rd_data_o, 64'h0000_0005_FFFF_FFF0);
            check_eq("t2_no_req", 64'(req_o), 64'd0);
        end
        finish_read();
        resp_lo = 32'hA5A5_0001;
        resp_hi = 32'h0000_0006;
        start_read();
        wait_valid(40, n, reqs, hi_reqs);
        check_eq("t2_fresh_lat", 64'(n), 64'd5);
        check_eq("t2_fresh_data", rd_data_o, 64'h0000_0006_A5A5_0001);
        finish_read();

        // 3: no ack at all -> timeout in low phase
        lo_en = 1'b0;
        start_read();
        wait_valid(60, n, reqs, hi_reqs);
        check_eq("t3_lat", 64'(n), 64'd17);
        check_eq("t3_reqs", 64'(reqs), 64'd1);
        check_eq("t3_hi_reqs", 64'(hi_reqs), 64'd0);
        check_eq("t3_err", 64'(rd_err_o), 64'd1);
        check_eq("t3_data", rd_data_o, 64'd0);
        finish_read();
        lo_en = 1'b1;

        // 4: delayed acks, then spurious acks in DONE and IDLE
        ack_dly = 3;
        resp_lo = 32'h1234_5678;
        resp_hi = 32'h9ABC_DEF0;
        start_read();
        wait_valid(60, n, reqs, hi_reqs);
        check_eq("t4_lat", 64'(n), 64'd9);
        check_eq("t4_data", rd_data_o, 64'h9ABC_DEF0_1234_5678);
        check_eq("t4_err", 64'(rd_err_o), 64'd0);
        spur_en = 1'b1;
        tick();
        tick();
        check_eq("t4_spur_done", rd_data_o, 64'h9ABC_DEF0_1234_5678);
        spur_en = 1'b0;
        tick();
        finish_read();
        spur_en = 1'b1;
        tick();
        tick();
        check_eq("t4_spur_idle_busy", 64'(rd_busy_o), 64'd0);
        check_eq("t4_spur_idle_data", rd_data_o, 64'h9ABC_DEF0_1234_5678);
        spur_en = 1'b0;
        tick();

        // ack on the very last wait cycle of each phase is a success
        ack_dly = 15;
        resp_lo = 32'h0BAD_F00D;
        resp_hi = 32'h0000_0077;
        start_read();
        wait_valid(80, n, reqs, hi_reqs);
        check_eq("lim_lat", 64'(n), 64'd33);
        check_eq("lim_err", 64'(rd_err_o), 64'd0);
        check_eq("lim_data", rd_data_o, 64'h0000_0077_0BAD_F00D);
        finish_read();

        // one cycle later is a timeout
        ack_dly = 16;
        start_read();
        wait_valid(80, n, reqs, hi_reqs);
        check_eq("late_lat", 64'(n), 64'd17);
        check_eq("late_err", 64'(rd_err_o), 64'd1);
        finish_read();
        tick();

        // high phase never acked
        ack_dly = 1;
        hi_en   = 1'b0;
        start_read();
        wait_valid(80, n, reqs, hi_reqs);
        check_eq("hi_to_lat", 64'(n), 64'd19);
        check_eq("hi_to_hi_reqs", 64'(hi_reqs), 64'd1);
        check_eq("hi_to_err_data", {rd_data_o[62:0], rd_err_o}, 64'd1);
        finish_read();
        hi_en = 1'b1;

        // 5: async reset during WAIT_HI
        ack_dly = 3;
        start_read();
        for (int i = 0; i < 5; i++) tick();
        check_eq("t5_pre_busy", 64'({rd_busy_o, req_o}), 64'b10);
        reset_n = 1'b0;
        #1;
        check_eq("t5_async_ctrl", 64'({rd_busy_o, rd_valid_o, req_o, atomic_o, rd_err_o}), 64'd0);
        check_eq("t5_async_data", rd_data_o, 64'd0);
        for (int i = 0; i < 4; i++) tick();
        reset_n = 1'b1;
        tick();
        ack_dly = 1;
        resp_lo = 32'hCAFE_0042;
        resp_hi = 32'h0000_0101;
        start_read();
        wait_valid(40, n, reqs, hi_reqs);
        check_eq("t5_after_lat", 64'(n), 64'd5);
        check_eq("t5_after_data", rd_data_o, 64'h0000_0101_CAFE_0042);
        finish_read();

        // 6: rd_req_i held high with ready=1
        rd_ready_i = 1'b1;
        rd_req_i   = 1'b1;
        accepts = 0;
        valids  = 0;
        for (int i = 0; i < 30; i++) begin
            if (rd_busy_o === 1'b0) accepts++;
            if (rd_valid_o === 1'b1) begin
                valids++;
                check_eq("t6_valid_cycle", 64'(i % 6), 64'd5);
            end
            tick();
        end
        rd_req_i = 1'b0;
        check_eq("t6_accepts", 64'(accepts), 64'd5);
        check_eq("t6_valids", 64'(valids), 64'd5);
        tick();
        tick();
        check_eq("t6_idle", 64'(rd_busy_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
